count_report_tx: RTL and testbench
==================================

COUNT_REPORT_TX -- requirements
Module: count_report_tx

Interface
REQ-001 Parameter: CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD, default 115200, serial bit rate.
REQ-003 Derived constant DIVISOR SHALL be floor(CLK_HZ/BAUD); the default is 104 clocks per bit.
REQ-004 clk_12m  input  1  the single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 count  input  8  unsigned press count to report.
REQ-007 send  input  1  report request, level-sensitive, sampled only in IDLE.
REQ-008 busy  output  1  high while a report is in progress.
REQ-009 done  output  1  one-cycle pulse when the final stop bit completes.
REQ-010 uart_tx  output  1  serial line, idles high.

Function
REQ-011 Each report SHALL be exactly 5 bytes, in this order:
- ASCII hundreds digit, tens digit and units digit of the latched count, with leading zeros kept;
- 0x0D;
- 0x0A.
REQ-012 Digit bytes SHALL equal 0x30 + digit; the decimal conversion SHALL be exact for 0..255.
REQ-013 In IDLE with send=1, the block SHALL latch count and the three digits on that edge, then enter START.
REQ-014 busy SHALL be high from the cycle after acceptance until the done cycle; busy and done are never high together.
REQ-015 The count input is ignored after the latch; changes mid-report do not alter the transmitted bytes.
REQ-016 send SHALL be ignored in any state other than IDLE; requests are not queued.
REQ-017 The state machine SHALL have four states:
- IDLE: uart_tx=1.
- START: uart_tx=0 for DIVISOR cycles.
- DATA: 8 bits sent LSB first, each held for DIVISOR cycles.
- STOP: uart_tx=1 for DIVISOR cycles.
REQ-018 Transitions: STOP with byte index < 4 SHALL go to START of the next byte with no idle gap; STOP with byte index = 4 SHALL go to IDLE.
REQ-019 uart_tx SHALL be driven from a register, glitch-free.
REQ-020 Latency: the start bit of byte 0 SHALL begin on the first cycle after the acceptance edge.
REQ-021 A full report SHALL last exactly 50*DIVISOR cycles; with defaults this is 5200 cycles.
REQ-022 The bit-period counter SHALL count 0..DIVISOR-1 and wrap. The bit index SHALL count 0..7 and wrap. The byte index SHALL count 0..4.
REQ-023 done SHALL pulse for one cycle on the cycle the state returns to IDLE.
REQ-024 If send=1 during the done cycle, a new report SHALL be accepted on that edge, latching the current count. The result is back-to-back frames with no extra idle cycle beyond the done cycle.

Reset
REQ-025 While rst=1, outputs SHALL be held at: uart_tx=1, busy=0, done=0. These values SHALL take effect immediately, without waiting for a clock edge.
REQ-026 Reset SHALL clear the state to IDLE and clear all counters, the byte index and the latched data to 0.
REQ-027 Reset mid-frame SHALL abort the report; no partial byte resumes after reset release.
REQ-028 The first send SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-029 count=0, single send pulse -> bytes 0x30,0x30,0x30,0x0D,0x0A; done exactly 5200 cycles after the start of the first start bit.
REQ-030 count=255 -> bytes 0x32,0x35,0x35,0x0D,0x0A; count=7 -> bytes 0x30,0x30,0x37,0x0D,0x0A.
REQ-031 Bit timing, checked with a line monitor:
- every bit is exactly 104 cycles;
- LSB first;
- stop bit is 1;
- no idle cycles between bytes.
REQ-032 count=42 is accepted, then during the report send pulses and count changes to 99 -> report is "042\r\n" only; no second frame.
REQ-033 send held high with count=1, then count=2 -> first frame "001\r\n"; second frame "002\r\n" starts the cycle after done.
REQ-034 rst asserted in the middle of DATA of byte 2 -> uart_tx=1 and busy=0 immediately; a send after release gives a complete, correct frame.

Source files
------------

// File: rtl/count_report_tx.sv
// count_report_tx: on request, latches an 8-bit count and transmits it as a
// 5-byte ASCII report ("ddd\r\n") over an 8N1 UART line.

module count_report_tx #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_12m,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       uart_tx
);

  localparam int unsigned DIVISOR = CLK_HZ / BAUD;
  localparam int unsigned CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [3:0]  dig_h_q, dig_t_q, dig_u_q;

  logic [3:0]  dig_h, dig_t, dig_u;
  logic [7:0]  rem;
  logic [7:0]  cur_byte;

  // Exact binary-to-decimal split of the live count input (0..255).
  always_comb begin
    dig_h = 4'(count / 8'd100);
    rem   = count % 8'd100;
    dig_t = 4'(rem / 8'd10);
    dig_u = 4'(rem % 8'd10);
  end

  // Select the report byte currently being serialised.
  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = {4'h3, dig_h_q};
      3'd1:    cur_byte = {4'h3, dig_t_q};
      3'd2:    cur_byte = {4'h3, dig_u_q};
      3'd3:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Report FSM; uart_tx, busy and done are all registered here.
  // uart_tx is loaded with the next line level on each bit boundary so the
  // line changes on the same edge the state/bit index advances.
  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      dig_h_q  <= '0;
      dig_t_q  <= '0;
      dig_u_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (send) begin
            dig_h_q  <= dig_h;
            dig_t_q  <= dig_t;
            dig_u_q  <= dig_u;
            byte_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= cur_byte[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx <= cur_byte[3'(bit_idx + 3'd1)];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (byte_idx == 3'd4) begin
              byte_idx <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              uart_tx  <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              uart_tx  <= 1'b0;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_report_tx.sv
// tb_count_report_tx: directed bench for count_report_tx with a cycle-exact
// line monitor sampling on the falling clock edge.

module tb_count_report_tx;

  localparam int BITC = 104;

  logic       clk_12m;
  logic       rst;
  logic [7:0] count;
  logic       send;
  logic       busy;
  logic       done;
  logic       uart_tx;

  int n_chk;
  int n_pass;

  count_report_tx #(
    .CLK_HZ(12000000),
    .BAUD  (115200)
  ) dut (
    .clk_12m(clk_12m),
    .rst    (rst),
    .count  (count),
    .send   (send),
    .busy   (busy),
    .done   (done),
    .uart_tx(uart_tx)
  );

  initial clk_12m = 1'b0;
  always #5 clk_12m = ~clk_12m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Called on the falling edge that is cycle 0 of the first start bit.
  // Samples all 50 bit periods back to back, then checks the done cycle.
  // mode: 0 none, 1 count->99 plus send pulse mid-frame, 2 count->2 mid-frame,
  //       3 drop send mid-frame.
  task automatic rx_frame(input string tag, input logic [39:0] exp, input int mode);
    logic [9:0] seen;
    logic       stable;
    logic       flags_ok;
    logic       v;
    int         cyc;
    flags_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      stable = 1'b1;
      seen   = '0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < BITC; c++) begin
          cyc = b * 10 * BITC + k * BITC + c;
          if (cyc == 1000) begin
            case (mode)
              1: begin count = 8'd99; send = 1'b1; end
              2: count = 8'd2;
              3: send = 1'b0;
              default: ;
            endcase
          end
          if (mode == 1 && cyc == 1010) send = 1'b0;
          v = uart_tx;
          if (c == 0) seen[k] = v;
          else if (v !== seen[k]) stable = 1'b0;
          if (busy !== 1'b1 || done !== 1'b0) flags_ok = 1'b0;
          @(negedge clk_12m);
        end
      end
      chk({tag, "_start"},  {31'd0, seen[0]}, 32'd0);
      chk({tag, "_byte"},   {24'd0, seen[8:1]}, {24'd0, exp[39 - 8*b -: 8]});
      chk({tag, "_stop"},   {31'd0, seen[9]}, 32'd1);
      chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
    end
    chk({tag, "_busy_in_frame"}, {31'd0, flags_ok}, 32'd1);
    chk({tag, "_done"},          {31'd0, done}, 32'd1);
    chk({tag, "_busy_at_done"},  {31'd0, busy}, 32'd0);
    chk({tag, "_tx_at_done"},    {31'd0, uart_tx}, 32'd1);
  endtask

  task automatic idle_check(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_12m);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Pulse send for one edge; returns on cycle 0 of the start bit.
  task automatic send_report(input logic [7:0] c);
    @(negedge clk_12m);
    count = c;
    send  = 1'b1;
    @(negedge clk_12m);
    send  = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    count  = '0;
    send   = 1'b0;

    repeat (3) @(negedge clk_12m);
    chk("rst_tx",   {31'd0, uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, busy},    32'd0);
    chk("rst_done", {31'd0, done},    32'd0);

    // First send on the first edge after reset release.
    rst   = 1'b0;
    count = 8'd0;
    send  = 1'b1;
    @(negedge clk_12m);
    send  = 1'b0;
    chk("lat_start_bit", {31'd0, uart_tx}, 32'd0);
    rx_frame("c000", {8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}, 0);
    idle_check("idle_after_000", 20);

    send_report(8'd255);
    rx_frame("c255", {8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A}, 0);
    idle_check("idle_after_255", 10);

    send_report(8'd7);
    rx_frame("c007", {8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A}, 0);
    idle_check("idle_after_007", 10);

    // Mid-report send pulses and count changes are ignored.
    send_report(8'd42);
    rx_frame("c042", {8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A}, 1);
    idle_check("no_second_frame", 300);

    // send held high: second frame starts right after the done cycle.
    @(negedge clk_12m);
    count = 8'd1;
    send  = 1'b1;
    @(negedge clk_12m);
    rx_frame("c001", {8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A}, 2);
    @(negedge clk_12m);
    chk("b2b_start_bit", {31'd0, uart_tx}, 32'd0);
    rx_frame("c002", {8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A}, 3);
    idle_check("idle_after_b2b", 20);

    // Reset during DATA of byte 2 (byte 2 DATA spans cycles 2184..3015).
    send_report(8'd200);
    repeat (2400) @(negedge clk_12m);
    rst = 1'b1;
    #1;
    chk("midrst_tx",   {31'd0, uart_tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy},    32'd0);
    chk("midrst_done", {31'd0, done},    32'd0);
    repeat (2) @(negedge clk_12m);
    rst = 1'b0;
    idle_check("no_resume_after_rst", 1200);

    send_report(8'd128);
    rx_frame("c128", {8'h31, 8'h32, 8'h38, 8'h0D, 8'h0A}, 0);
    idle_check("idle_final", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
